// File: rtl/disp_scan_ctrl_pkg.sv
// Shared display constants and helpers for the digit scan controller.
//   NUM_DIGITS : number of multiplexed digits
//   DIGIT_W    : bits per hex digit
//   an_decode  : digit index -> active-low one-cold anode select
package disp_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int DATA_W     = NUM_DIGITS * DIGIT_W;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic [NUM_DIGITS-1:0] an_decode(input idx_t idx);
        logic [NUM_DIGITS-1:0] one_hot;
        one_hot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_tick_gen.sv
// Digit-slot prescaler: counts 0..DIV-1 and wraps.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   tick_o : high during the last cycle of each slot (count == DIV-1)
module scan_tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick_o = (r_cnt == LAST);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed display scan controller with frame-synchronous
// shadow reload and per-digit blinking.
//   clk, rst     : system clock, synchronous active-high reset
//   data_i       : eight hex digits, digit k at [4k+3:4k]
//   point_i      : decimal-point request per digit
//   le_i         : per-digit enable for the segment stage
//   blink_i      : per-digit blink enable
//   upd_req_i    : one-cycle request to reload the shadow registers
//   upd_done_o   : one-cycle acknowledge of a completed reload
//   an_o         : active-low digit select
//   hex_o, point_o, le_o, flash_o : attributes of the selected digit
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [NUM_DIGITS-1:0] point_i,
    input  logic [NUM_DIGITS-1:0] le_i,
    input  logic [NUM_DIGITS-1:0] blink_i,
    input  logic                  upd_req_i,
    output logic                  upd_done_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [DIGIT_W-1:0]    hex_o,
    output logic                  point_o,
    output logic                  le_o,
    output logic                  flash_o
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);
    localparam idx_t       IDX_LAST   = idx_t'(NUM_DIGITS - 1);

    logic                  w_tick;
    logic                  w_frame;
    idx_t                  r_idx;
    logic [7:0]            r_blink_cnt;
    logic                  r_phase;
    logic                  r_pending;
    logic                  r_upd_done;
    logic [DATA_W-1:0]     r_sh_data;
    logic [NUM_DIGITS-1:0] r_sh_point;
    logic [NUM_DIGITS-1:0] r_sh_le;
    logic [NUM_DIGITS-1:0] r_sh_blink;
    logic [DIGIT_W-1:0]    w_hex;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (w_tick)
    );

    assign w_frame = w_tick && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_pending   <= 1'b0;
            r_upd_done  <= 1'b0;
            r_sh_data   <= '0;
            r_sh_point  <= '0;
            r_sh_le     <= '0;
            r_sh_blink  <= '0;
        end else begin
            r_upd_done <= 1'b0;
            if (w_tick) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_frame) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
            // Reload only between frames so a frame is never torn; a request
            // arriving on the boundary itself is served immediately.
            if (w_frame && (r_pending || upd_req_i)) begin
                r_sh_data  <= data_i;
                r_sh_point <= point_i;
                r_sh_le    <= le_i;
                r_sh_blink <= blink_i;
                r_pending  <= 1'b0;
                r_upd_done <= 1'b1;
            end else if (upd_req_i) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_hex = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == idx_t'(k)) begin
                w_hex = r_sh_data[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign upd_done_o = r_upd_done;
    assign an_o       = an_decode(r_idx);
    assign hex_o      = w_hex;
    assign point_o    = r_sh_point[r_idx];
    assign le_o       = r_sh_le[r_idx];
    assign flash_o    = ~r_sh_blink[r_idx] | r_phase;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed testbench for disp_scan_ctrl with SCAN_DIV=4, BLINK_DIV=2.
// Time index t counts cycles since the last reset edge: slot = t/4,
// frame = t/32, and the first frame boundary edge is t=31 -> t=32.
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] data_i;
    logic [7:0]  point_i;
    logic [7:0]  le_i;
    logic [7:0]  blink_i;
    logic        upd_req_i;
    logic        upd_done_o;
    logic [7:0]  an_o;
    logic [3:0]  hex_o;
    logic        point_o;
    logic        le_o;
    logic        flash_o;

    int errors = 0;
    int checks = 0;
    int t      = 0;

    logic [7:0] an_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    disp_scan_ctrl #(
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .point_i    (point_i),
        .le_i       (le_i),
        .blink_i    (blink_i),
        .upd_req_i  (upd_req_i),
        .upd_done_o (upd_done_o),
        .an_o       (an_o),
        .hex_o      (hex_o),
        .point_o    (point_o),
        .le_o       (le_o),
        .flash_o    (flash_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic step_to(input int target);
        if (target > t) step(target - t);
    endtask

    task automatic do_reset();
        upd_req_i = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        t = 0;
    endtask

    task automatic pulse_req();
        upd_req_i = 1'b1;
        step(1);
        upd_req_i = 1'b0;
    endtask

    task automatic test_reset();
        data_i = 32'hFFFF_FFFF; point_i = 8'hFF; le_i = 8'hFF; blink_i = 8'hFF;
        do_reset();
        checks++; if (an_o !== 8'hFE) begin errors++;
            $display("FAIL reset_an: got %h want fe", an_o); end
        checks++; if (hex_o !== 4'h0) begin errors++;
            $display("FAIL reset_hex: got %h want 0", hex_o); end
        checks++; if (point_o !== 1'b0) begin errors++;
            $display("FAIL reset_point: got %b want 0", point_o); end
        checks++; if (le_o !== 1'b0) begin errors++;
            $display("FAIL reset_le: got %b want 0", le_o); end
        checks++; if (flash_o !== 1'b1) begin errors++;
            $display("FAIL reset_flash: got %b want 1", flash_o); end
        checks++; if (upd_done_o !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b want 0", upd_done_o); end
    endtask

    task automatic test_scan_order();
        do_reset();
        for (int c = 0; c < 36; c++) begin
            checks++;
            if (an_o !== an_tbl[(t / 4) % 8]) begin
                errors++;
                $display("FAIL scan_an t=%0d: got %h want %h", t, an_o, an_tbl[(t / 4) % 8]);
            end
            step(1);
        end
    endtask

    task automatic test_reload();
        logic [3:0] exp_hex;
        do_reset();
        data_i = 32'h89AB_CDEF; point_i = 8'h81; le_i = 8'hF0; blink_i = 8'h00;
        step_to(5);
        pulse_req();
        step_to(31);
        checks++; if (upd_done_o !== 1'b0 || hex_o !== 4'h0) begin errors++;
            $display("FAIL reload_early: done=%b hex=%h want done=0 hex=0", upd_done_o, hex_o); end
        step(1);
        checks++; if (upd_done_o !== 1'b1) begin errors++;
            $display("FAIL reload_done: got %b want 1 at t=32", upd_done_o); end
        step(1);
        checks++; if (upd_done_o !== 1'b0) begin errors++;
            $display("FAIL reload_done_width: got %b want 0 at t=33", upd_done_o); end
        for (int k = 0; k < 8; k++) begin
            step_to(32 + 4 * k + 2);
            exp_hex = 4'(15 - k);
            checks++;
            if (hex_o !== exp_hex || point_o !== (k == 0 || k == 7) || le_o !== (k >= 4)) begin
                errors++;
                $display("FAIL reload_digit%0d: hex=%h pt=%b le=%b want hex=%h pt=%b le=%b",
                         k, hex_o, point_o, le_o, exp_hex, (k == 0 || k == 7), (k >= 4));
            end
        end
    endtask

    // Continues from test_reload without reset: change data mid-frame, no request.
    task automatic test_no_tear();
        logic [3:0] exp_hex;
        data_i = 32'h1234_5678;
        for (int k = 0; k < 16; k++) begin
            step_to(64 + 4 * k + 1);
            exp_hex = 4'(15 - (k % 8));
            checks++;
            if (hex_o !== exp_hex || upd_done_o !== 1'b0) begin
                errors++;
                $display("FAIL no_tear slot%0d: hex=%h done=%b want hex=%h done=0",
                         k, hex_o, upd_done_o, exp_hex);
            end
        end
    endtask

    task automatic test_blink();
        logic exp0;
        do_reset();
        data_i = 32'h0; point_i = 8'h0; le_i = 8'hFF; blink_i = 8'h01;
        step_to(1);
        pulse_req();
        for (int f = 1; f < 8; f++) begin
            exp0 = ((f / 2) % 2) == 1;
            step_to(32 * f + 1);
            checks++;
            if (flash_o !== exp0) begin errors++;
                $display("FAIL blink_d0 frame%0d: got %b want %b", f, flash_o, exp0); end
            step_to(32 * f + 13);
            checks++;
            if (flash_o !== 1'b1) begin errors++;
                $display("FAIL blink_d3 frame%0d: got %b want 1", f, flash_o); end
        end
    endtask

    task automatic test_coincidence();
        int n_done;
        int done_t;
        do_reset();
        data_i = 32'h0123_4567; point_i = 8'h0; le_i = 8'h0; blink_i = 8'h01;
        step_to(31);
        upd_req_i = 1'b1;
        checks++; if (upd_done_o !== 1'b0) begin errors++;
            $display("FAIL coinc_pre: got %b want 0", upd_done_o); end
        step(1);
        upd_req_i = 1'b0;
        checks++; if (upd_done_o !== 1'b1 || hex_o !== 4'h7) begin errors++;
            $display("FAIL coinc_load: done=%b hex=%h want done=1 hex=7", upd_done_o, hex_o); end
        step_to(40);
        data_i = 32'hFEDC_BA98; blink_i = 8'h02;
        pulse_req();
        step_to(50);
        pulse_req();
        n_done = 0;
        done_t = -1;
        while (t < 110) begin
            step(1);
            if (upd_done_o === 1'b1) begin n_done++; done_t = t; end
            if (t == 64) begin
                checks++; if (hex_o !== 4'h8) begin errors++;
                    $display("FAIL coinc_hex: got %h want 8", hex_o); end
            end
            if (t == 68) begin
                checks++; if (flash_o !== 1'b1) begin errors++;
                    $display("FAIL coinc_phase: got %b want 1", flash_o); end
            end
        end
        checks++; if (n_done != 1 || done_t != 64) begin errors++;
            $display("FAIL coinc_single_done: count=%0d at t=%0d want 1 at t=64", n_done, done_t);
        end
        step_to(129);
        checks++; if (flash_o !== 1'b1) begin errors++;
            $display("FAIL coinc_newmask_d0: got %b want 1", flash_o); end
        step_to(133);
        checks++; if (flash_o !== 1'b0) begin errors++;
            $display("FAIL coinc_newmask_d1: got %b want 0", flash_o); end
    endtask

    task automatic test_reset_pending();
        int n_done;
        do_reset();
        data_i = 32'hDEAD_BEEF; point_i = 8'hFF; le_i = 8'hFF; blink_i = 8'hFF;
        step_to(3);
        pulse_req();
        step_to(22);
        checks++; if (an_o !== 8'hDF) begin errors++;
            $display("FAIL rstp_idx5: got %h want df", an_o); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        t = 0;
        checks++;
        if (an_o !== 8'hFE || hex_o !== 4'h0 || point_o !== 1'b0 || le_o !== 1'b0 ||
            flash_o !== 1'b1 || upd_done_o !== 1'b0) begin
            errors++;
            $display("FAIL rstp_outputs: an=%h hex=%h pt=%b le=%b fl=%b done=%b want fe 0 0 0 1 0",
                     an_o, hex_o, point_o, le_o, flash_o, upd_done_o);
        end
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (upd_done_o === 1'b1) n_done++;
        end
        checks++; if (n_done != 0 || hex_o !== 4'h0) begin errors++;
            $display("FAIL rstp_discard: done_count=%0d hex=%h want 0 and 0", n_done, hex_o); end
    endtask

    initial begin
        rst = 1'b1; upd_req_i = 1'b0;
        data_i = '0; point_i = '0; le_i = '0; blink_i = '0;
        test_reset();
        test_scan_order();
        test_reload();
        test_no_tear();
        test_blink();
        test_coincidence();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
